btb_bht_predictor: RTL and testbench
====================================

Name: btb_bht_predictor

Overview:
IF-stage branch predictor: a direct-mapped branch target buffer with a per-entry 2-bit saturating counter.
- Looks up PC_IF combinationally and produces taken_IF and the predicted next PC. taken_IF is carried down the pipe through the IF/ID PC segment register.
- Updated one entry per cycle from EX-stage branch resolution.
- Keeps branch and mispredict counters for lab statistics.

Parameters:
INDEX_W, 6, index width; table depth = 2^INDEX_W entries
TAG_W, 24, tag width; must equal 30-INDEX_W (PC[31:INDEX_W+2])

Ports:
clk  input  1  clock, all state updates on posedge
rst_n  input  1  asynchronous active-low reset
PC_IF  input  32  current fetch address (word aligned)
taken_IF  output  1  prediction: branch taken at PC_IF
pred_target_IF  output  32  stored target when taken_IF=1, else PC_IF+4
br_EX  input  1  instruction in EX is a conditional branch, resolved this cycle
PC_EX  input  32  address of the branch in EX
br_taken_EX  input  1  actual direction
br_target_EX  input  32  actual taken target
taken_EX  input  1  prediction made for this branch (taken_IF carried down the pipe)
mispredict_EX  output  1  combinational; prediction wrong, EX must flush and redirect
branch_cnt  output  32  resolved conditional branches since reset
mispredict_cnt  output  32  mispredictions since reset

Behaviour:
- Entry fields: valid(1), tag(TAG_W), target(32), ctr(2).
  - idx = PC[INDEX_W+1:2]; tag = PC[31:INDEX_W+2].
- Reset (async, rst_n=0): all valid=0, ctr=2'b01, target=0, tag=0. branch_cnt=0, mispredict_cnt=0.
  - Outputs during/after reset: taken_IF=0, pred_target_IF=PC_IF+4, mispredict_EX computed from inputs only.
  - Reset mid-operation discards all learned state immediately.
- Lookup (combinational, 0 latency):
  - hit = valid[idx] && tag[idx]==tag(PC_IF).
  - taken_IF = hit && ctr[1].
  - pred_target_IF = taken_IF ? target[idx] : PC_IF+4, with 32-bit wrap (0xFFFFFFFC+4 = 0).
- Mispredict (combinational, valid only when br_EX=1, else 0). mispredict_EX = 1 when any of:
  - taken_EX != br_taken_EX;
  - taken_EX && br_taken_EX && lookup-at-update target != br_target_EX.
  - The lookup-at-update uses the current table entry at idx(PC_EX), read before this cycle's write.
- Update (posedge, only when br_EX=1), with e = entry at idx(PC_EX):
  - Hit, taken: ctr saturating increment (max 2'b11); target <= br_target_EX.
  - Hit, not taken: ctr saturating decrement (min 2'b00); target unchanged.
  - Miss, taken: allocate. valid=1, tag, target=br_target_EX, ctr=2'b10 (weakly taken). Replaces any aliasing entry.
  - Miss, not taken: no change.
  - br_EX=0: table untouched.
- Counters:
  - branch_cnt += 1 when br_EX.
  - mispredict_cnt += 1 when br_EX && mispredict_EX.
  - Both wrap at 2^32.
- Simultaneous lookup and update of the same idx: lookup returns pre-update contents. New contents are visible from the next cycle; no bypass.
- Single write port; the table may be registers or distributed RAM with async read.
- Non-branch instructions never allocate. Jumps (jal/jalr) are outside this block.

Test Plan:
1. Reset, then PC_IF=0x100 -> taken_IF=0, pred_target_IF=0x104; both counters 0.
2. Branch at 0x100, taken, target 0x80, taken_EX=0 -> mispredict_EX=1; next cycle PC_IF=0x100 gives taken_IF=1, pred_target_IF=0x80; branch_cnt=1, mispredict_cnt=1.
3. Same branch resolved taken 3 more times -> ctr saturates at 11; then 1 not-taken -> ctr=10, taken_IF still 1; second not-taken -> ctr=01, taken_IF=0.
4. Aliasing: with INDEX_W=6, allocate 0x100 then a taken branch at 0x1100 (same idx, different tag) -> lookup 0x100 misses (taken_IF=0); lookup 0x1100 hits.
5. Same-cycle update and lookup of 0x200 (first taken resolution) -> that cycle taken_IF=0; the following cycle taken_IF=1.
6. Predicted taken with correct direction but br_target_EX=0x300 vs stored 0x80 -> mispredict_EX=1, stored target becomes 0x300. Separately, assert rst_n low mid-run -> taken_IF drops to 0 without a clock edge.

Source files
------------

// File: rtl/btb_bht_predictor.sv
// rtl/btb_bht_predictor.sv - direct-mapped BTB with 2-bit counters, EX-stage update and mispredict statistics
module btb_bht_predictor #(
    parameter int INDEX_W = 6,
    parameter int TAG_W   = 24
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] PC_IF,
    output logic        taken_IF,
    output logic [31:0] pred_target_IF,
    input  logic        br_EX,
    input  logic [31:0] PC_EX,
    input  logic        br_taken_EX,
    input  logic [31:0] br_target_EX,
    input  logic        taken_EX,
    output logic        mispredict_EX,
    output logic [31:0] branch_cnt,
    output logic [31:0] mispredict_cnt
);

    localparam int DEPTH = 1 << INDEX_W;

    logic             valid_q  [DEPTH];
    logic [TAG_W-1:0] tag_q    [DEPTH];
    logic [31:0]      target_q [DEPTH];
    logic [1:0]       ctr_q    [DEPTH];

    logic [INDEX_W-1:0] idx_if;
    logic [TAG_W-1:0]   tag_if;
    logic [INDEX_W-1:0] idx_ex;
    logic [TAG_W-1:0]   tag_ex;
    logic               hit_if;
    logic               hit_ex;
    logic [1:0]         ctr_ex;
    logic               unused_pc_ex_lsbs;

    assign idx_if = PC_IF[INDEX_W+1:2];
    assign tag_if = PC_IF[31:INDEX_W+2];
    assign idx_ex = PC_EX[INDEX_W+1:2];
    assign tag_ex = PC_EX[31:INDEX_W+2];
    assign unused_pc_ex_lsbs = &{1'b0, PC_EX[1:0]};

    // Lookup reads the registered table, so a same-cycle update is not bypassed.
    assign hit_if         = valid_q[idx_if] && (tag_q[idx_if] == tag_if);
    assign taken_IF       = hit_if && ctr_q[idx_if][1];
    assign pred_target_IF = taken_IF ? target_q[idx_if] : PC_IF + 32'd4;

    assign hit_ex = valid_q[idx_ex] && (tag_q[idx_ex] == tag_ex);
    assign ctr_ex = ctr_q[idx_ex];

    always_comb begin
        mispredict_EX = 1'b0;
        if (br_EX) begin
            if (taken_EX != br_taken_EX)
                mispredict_EX = 1'b1;
            else if (taken_EX && (target_q[idx_ex] != br_target_EX))
                mispredict_EX = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= 2'b01;
            end
        end else if (br_EX) begin
            if (hit_ex) begin
                if (br_taken_EX) begin
                    ctr_q[idx_ex]    <= (ctr_ex == 2'b11) ? 2'b11 : ctr_ex + 2'd1;
                    target_q[idx_ex] <= br_target_EX;
                end else begin
                    ctr_q[idx_ex] <= (ctr_ex == 2'b00) ? 2'b00 : ctr_ex - 2'd1;
                end
            end else if (br_taken_EX) begin
                // Allocation evicts whatever branch aliased onto this index.
                valid_q[idx_ex]  <= 1'b1;
                tag_q[idx_ex]    <= tag_ex;
                target_q[idx_ex] <= br_target_EX;
                ctr_q[idx_ex]    <= 2'b10;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            branch_cnt     <= '0;
            mispredict_cnt <= '0;
        end else if (br_EX) begin
            branch_cnt <= branch_cnt + 32'd1;
            if (mispredict_EX)
                mispredict_cnt <= mispredict_cnt + 32'd1;
        end
    end

endmodule

// File: tb/tb_btb_bht_predictor.sv
// tb/tb_btb_bht_predictor.sv - directed table-driven bench for btb_bht_predictor
module tb_btb_bht_predictor;

    logic        clk;
    logic        rst_n;
    logic [31:0] PC_IF;
    logic        taken_IF;
    logic [31:0] pred_target_IF;
    logic        br_EX;
    logic [31:0] PC_EX;
    logic        br_taken_EX;
    logic [31:0] br_target_EX;
    logic        taken_EX;
    logic        mispredict_EX;
    logic [31:0] branch_cnt;
    logic [31:0] mispredict_cnt;

    int n_checks = 0;
    int n_fails  = 0;

    btb_bht_predictor #(.INDEX_W(6), .TAG_W(24)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .PC_IF          (PC_IF),
        .taken_IF       (taken_IF),
        .pred_target_IF (pred_target_IF),
        .br_EX          (br_EX),
        .PC_EX          (PC_EX),
        .br_taken_EX    (br_taken_EX),
        .br_target_EX   (br_target_EX),
        .taken_EX       (taken_EX),
        .mispredict_EX  (mispredict_EX),
        .branch_cnt     (branch_cnt),
        .mispredict_cnt (mispredict_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc_if;
        logic        br;
        logic [31:0] pc_ex;
        logic        br_taken;
        logic [31:0] br_target;
        logic        taken_ex;
        logic        exp_taken;
        logic [31:0] exp_pred;
        logic        exp_mis;
        logic [31:0] exp_bc;
        logic [31:0] exp_mc;
    } vec_t;

    localparam int NV = 19;
    vec_t vecs [NV];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    initial begin
        // pc_if, br, pc_ex, br_taken, br_target, taken_ex | taken, pred, mis, bc, mc (checked before the edge)
        vecs[0]  = '{32'h100, 0, 32'h0,   0, 32'h0,   0, 0, 32'h104, 0, 0, 0};
        vecs[1]  = '{32'h100, 1, 32'h100, 1, 32'h80,  0, 0, 32'h104, 1, 0, 0};
        vecs[2]  = '{32'h100, 0, 32'h0,   0, 32'h0,   0, 1, 32'h80,  0, 1, 1};
        vecs[3]  = '{32'h100, 1, 32'h100, 1, 32'h80,  1, 1, 32'h80,  0, 1, 1};
        vecs[4]  = '{32'h100, 1, 32'h100, 1, 32'h80,  1, 1, 32'h80,  0, 2, 1};
        vecs[5]  = '{32'h100, 1, 32'h100, 1, 32'h80,  1, 1, 32'h80,  0, 3, 1};
        vecs[6]  = '{32'h100, 1, 32'h100, 0, 32'h0,   1, 1, 32'h80,  1, 4, 1};
        vecs[7]  = '{32'h100, 0, 32'h0,   0, 32'h0,   0, 1, 32'h80,  0, 5, 2};
        vecs[8]  = '{32'h100, 1, 32'h100, 0, 32'h0,   1, 1, 32'h80,  1, 5, 2};
        vecs[9]  = '{32'h100, 0, 32'h0,   0, 32'h0,   0, 0, 32'h104, 0, 6, 3};
        vecs[10] = '{32'h1100,1, 32'h1100,1, 32'h900, 0, 0, 32'h1104,1, 6, 3};
        vecs[11] = '{32'h100, 0, 32'h0,   0, 32'h0,   0, 0, 32'h104, 0, 7, 4};
        vecs[12] = '{32'h1100,0, 32'h0,   0, 32'h0,   0, 1, 32'h900, 0, 7, 4};
        vecs[13] = '{32'h200, 1, 32'h200, 1, 32'h240, 0, 0, 32'h204, 1, 7, 4};
        vecs[14] = '{32'h200, 0, 32'h0,   0, 32'h0,   0, 1, 32'h240, 0, 8, 5};
        vecs[15] = '{32'h104, 1, 32'h104, 1, 32'h80,  0, 0, 32'h108, 1, 8, 5};
        vecs[16] = '{32'h104, 1, 32'h104, 1, 32'h300, 1, 1, 32'h80,  1, 9, 6};
        vecs[17] = '{32'h104, 0, 32'h0,   0, 32'h0,   0, 1, 32'h300, 0, 10, 7};
        vecs[18] = '{32'hFFFFFFFC, 0, 32'h104, 0, 32'h0, 1, 0, 32'h0, 0, 10, 7};

        rst_n = 1'b0;
        PC_IF = 32'h100; br_EX = 1'b0; PC_EX = '0; br_taken_EX = 1'b0;
        br_target_EX = '0; taken_EX = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        for (int i = 0; i < NV; i++) begin
            PC_IF        = vecs[i].pc_if;
            br_EX        = vecs[i].br;
            PC_EX        = vecs[i].pc_ex;
            br_taken_EX  = vecs[i].br_taken;
            br_target_EX = vecs[i].br_target;
            taken_EX     = vecs[i].taken_ex;
            @(negedge clk);
            check($sformatf("v%0d taken_IF", i), {31'b0, taken_IF}, {31'b0, vecs[i].exp_taken});
            check($sformatf("v%0d pred_target_IF", i), pred_target_IF, vecs[i].exp_pred);
            check($sformatf("v%0d mispredict_EX", i), {31'b0, mispredict_EX}, {31'b0, vecs[i].exp_mis});
            check($sformatf("v%0d branch_cnt", i), branch_cnt, vecs[i].exp_bc);
            check($sformatf("v%0d mispredict_cnt", i), mispredict_cnt, vecs[i].exp_mc);
            @(posedge clk);
            #1;
        end

        // Asynchronous reset mid-run wipes the table without a clock edge.
        br_EX = 1'b0; PC_IF = 32'h104;
        #1 check("pre_reset taken_IF", {31'b0, taken_IF}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("async_reset taken_IF", {31'b0, taken_IF}, 32'd0);
        check("async_reset pred_target_IF", pred_target_IF, 32'h108);
        check("async_reset branch_cnt", branch_cnt, 32'd0);
        check("async_reset mispredict_cnt", mispredict_cnt, 32'd0);
        br_EX = 1'b1; PC_EX = 32'h104; taken_EX = 1'b1; br_taken_EX = 1'b0;
        #1 check("in_reset mispredict_EX", {31'b0, mispredict_EX}, 32'd1);
        br_EX = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        PC_IF = 32'h200;
        @(negedge clk);
        check("post_reset taken_IF 0x200", {31'b0, taken_IF}, 32'd0);
        check("post_reset pred 0x200", pred_target_IF, 32'h204);
        check("post_reset branch_cnt", branch_cnt, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
